// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register responder: register offsets,
// STATUS/CONTROL bit positions and the serial FSM state encodings.
package uart_reg_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_DIV     = 2'd3;

    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_FIFO_FULL  = 4;

    localparam int CTL_ENABLE   = 0;
    localparam int CTL_RX_IE    = 1;
    localparam int CTL_LOOPBACK = 2;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes. A push on a full FIFO succeeds when a
// pop happens in the same cycle; pointers carry one extra wrap bit.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_reg_responder.sv
// UART on the io_reg_* bus: DATA/STATUS/CONTROL/DIV registers, RX FIFO, TX.
// Optional macro UART_LOOPBACK_EN adds CONTROL.loopback (RX fed from TX).
module uart_reg_responder
    import uart_reg_pkg::*;
#(
    parameter int DEFAULT_DIV   = 434,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int DIV_W         = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_reg_valid,
    input  logic [31:0] io_reg_addr,
    input  logic [31:0] io_reg_wdata,
    input  logic        io_reg_wen,
    input  logic        io_reg_ren,
    output logic [31:0] io_reg_rdata,
    output logic        io_reg_ready,
    input  logic        io_uart_rx,
    output logic        io_uart_tx,
    output logic        io_irq
);
`ifdef UART_LOOPBACK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

    logic             ready_q, overrun_q, frame_err_q;
    logic [31:0]      rdata_q, rd_mux;
    logic [2:0]       ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic             accept, is_wr, is_rd, enable, tx_ready, tx_load;
    logic [1:0]       reg_sel;
    logic [4:0]       status_w;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       fifo_head;
    logic             rx_in, rx_s, rx_prev, rx_push, rx_ferr_set, tx_line;
    logic [1:0]       rx_sync;
    logic             unused_addr_bits;

    rx_state_e        rx_state, rx_state_d;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit, rx_bit_d;
    logic [7:0]       rx_shift, rx_shift_d;
    tx_state_e        tx_state, tx_state_d;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;

    assign unused_addr_bits = ^{io_reg_addr[31:4], io_reg_addr[1:0]};

    // The held request is accepted once; ready_q masks it during the pulse
    assign accept   = io_reg_valid && !ready_q;
    assign is_wr    = io_reg_wen;
    assign is_rd    = io_reg_ren && !io_reg_wen;
    assign reg_sel  = io_reg_addr[3:2];
    assign enable   = ctrl_q[CTL_ENABLE];
    assign tx_ready = (tx_state == TX_IDLE);
    assign fifo_pop = accept && is_rd && (reg_sel == REG_DATA) && !fifo_empty;
    assign tx_load  = accept && is_wr && (reg_sel == REG_DATA) && tx_ready && enable;

    assign io_reg_ready = ready_q;
    assign io_reg_rdata = rdata_q;
    assign io_uart_tx   = tx_line;
    assign io_irq       = !fifo_empty && ctrl_q[CTL_RX_IE];

    always_comb begin
        status_w                = '0;
        status_w[ST_TX_READY]   = tx_ready;
        status_w[ST_RX_VALID]   = !fifo_empty;
        status_w[ST_RX_OVERRUN] = overrun_q;
        status_w[ST_FRAME_ERR]  = frame_err_q;
        status_w[ST_FIFO_FULL]  = fifo_full;
        rd_mux                  = '0;
        case (reg_sel)
            REG_DATA:    if (!fifo_empty) rd_mux[7:0] = fifo_head;
            REG_STATUS:  rd_mux[4:0] = status_w;
            REG_CONTROL: rd_mux[2:0] = ctrl_q;
            default:     rd_mux[DIV_W-1:0] = div_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            div_q       <= DIV_RESET;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= (accept && is_rd) ? rd_mux : '0;
            if (accept && is_wr) begin
                case (reg_sel)
                    REG_STATUS: begin
                        if (io_reg_wdata[ST_RX_OVERRUN]) overrun_q   <= 1'b0;
                        if (io_reg_wdata[ST_FRAME_ERR])  frame_err_q <= 1'b0;
                    end
                    REG_CONTROL: ctrl_q <= io_reg_wdata[2:0] & CTRL_MASK;
                    REG_DIV: div_q <= (io_reg_wdata < 32'(MIN_DIV)) ? DIV_W'(MIN_DIV)
                                                                     : io_reg_wdata[DIV_W-1:0];
                    default: ;
                endcase
            end
            // A new error event wins over a simultaneous W1C
            if (rx_push && fifo_full && !fifo_pop) overrun_q <= 1'b1;
            if (rx_ferr_set) frame_err_q <= 1'b1;
        end
    end

    uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef UART_LOOPBACK_EN
    assign rx_in = ctrl_q[CTL_LOOPBACK] ? tx_line : io_uart_rx;
`else
    assign rx_in = io_uart_rx;
`endif
    assign rx_s = rx_sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_div_q <= DIV_RESET;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_div_q <= DIV_RESET;
        end else begin
            rx_sync  <= {rx_sync[0], rx_in};
            rx_prev  <= rx_s;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_div_q <= rx_div_d;
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_div_q <= tx_div_d;
        end
    end

    // RX: start bit re-checked at half a bit, data and stop sampled mid-bit
    always_comb begin
        rx_state_d  = rx_state;
        rx_cnt_d    = rx_cnt + ONE;
        rx_bit_d    = rx_bit;
        rx_shift_d  = rx_shift;
        rx_div_d    = rx_div_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_q;
                end
            end
            RX_START: if (rx_cnt == (rx_div_q >> 1) - ONE) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == rx_div_q - ONE) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift[7:1]};
                rx_bit_d   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_d = RX_STOP;
            end
            default: if (rx_cnt == rx_div_q - ONE) begin
                rx_cnt_d    = '0;
                rx_state_d  = RX_IDLE;
                rx_push     = rx_s;
                rx_ferr_set = !rx_s;
            end
        endcase
        if (!enable) begin
            rx_state_d  = RX_IDLE;
            rx_push     = 1'b0;
            rx_ferr_set = 1'b0;
        end
    end

    // TX: the divisor is captured at load so a DIV write never stretches a frame
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + ONE;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_div_d   = tx_div_q;
        tx_line    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_state_d = TX_START;
                    tx_shift_d = io_reg_wdata[7:0];
                    tx_div_d   = div_q;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_cnt == tx_div_q - ONE) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_cnt == tx_div_q - ONE) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift >> 1;
                    tx_bit_d   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_d = TX_STOP;
                end
            end
            default: if (tx_cnt == tx_div_q - ONE) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Randomized bench for uart_reg_responder with a queue-based model of the
// RX FIFO and STATUS flags.
module tb_uart_reg_responder;
    localparam int DEPTH = 4;
    localparam int DIV   = 16;
    localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_CONTROL = 32'h8, A_DIV = 32'hC;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        io_reg_valid, io_reg_wen, io_reg_ren, io_reg_ready;
    logic [31:0] io_reg_addr, io_reg_wdata, io_reg_rdata;
    logic        io_uart_rx, io_uart_tx, io_irq;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] model_q[$];
    bit m_ovr, m_ferr;

    uart_reg_responder #(.DEFAULT_DIV(434), .RX_FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_reg_valid (io_reg_valid),
        .io_reg_addr  (io_reg_addr),
        .io_reg_wdata (io_reg_wdata),
        .io_reg_wen   (io_reg_wen),
        .io_reg_ren   (io_reg_ren),
        .io_reg_rdata (io_reg_rdata),
        .io_reg_ready (io_reg_ready),
        .io_uart_rx   (io_uart_rx),
        .io_uart_tx   (io_uart_tx),
        .io_irq       (io_irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (model_q.size() >= DEPTH) m_ovr = 1'b1;
        else model_q.push_back(b);
    endfunction

    function automatic logic [31:0] model_status(input bit tx_rdy);
        return {27'd0, model_q.size() == DEPTH, m_ferr, m_ovr, model_q.size() != 0, tx_rdy};
    endfunction

    function automatic logic [31:0] model_pop();
        if (model_q.size() == 0) return 32'd0;
        return {24'd0, model_q.pop_front()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input bit wr, output logic [31:0] rdata);
        int n;
        @(negedge clock);
        io_reg_addr  = addr;
        io_reg_wdata = wdata;
        io_reg_wen   = wr;
        io_reg_ren   = !wr;
        io_reg_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (io_reg_ready !== 1'b1 && n < 8);
        rdata        = io_reg_rdata;
        io_reg_valid = 1'b0;
        io_reg_wen   = 1'b0;
        io_reg_ren   = 1'b0;
        vectors++;
        if (io_reg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bus_timeout addr=%h ready=%b want 1", addr, io_reg_ready);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            io_uart_rx = fr[i];
            repeat (DIV) @(negedge clock);
        end
        io_uart_rx = 1'b1;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic setup_uart(input logic [31:0] ctrl);
        logic [31:0] d;
        bus_access(A_DIV, DIV, 1'b1, d);
        bus_access(A_CONTROL, ctrl, 1'b1, d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        vectors++;
        if (io_reg_ready !== 1'b0 || io_reg_rdata !== 32'd0 || io_uart_tx !== 1'b1 || io_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got ready=%b rdata=%h tx=%b irq=%b want 0 0 1 0",
                     io_reg_ready, io_reg_rdata, io_uart_tx, io_irq);
        end
        bus_access(A_STATUS, 0, 1'b0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL reset_status got=%h want=1", d); end
        @(posedge clock);
        #1;
        vectors++;
        if (io_reg_ready !== 1'b0) begin miscompares++; $display("FAIL ready_pulse_width got=%b want=0", io_reg_ready); end
        bus_access(A_DIV, 0, 1'b0, d);
        vectors++;
        if (d !== 32'd434) begin miscompares++; $display("FAIL reset_div got=%0d want=434", d); end
        bus_access(A_CONTROL, 0, 1'b0, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL reset_control got=%h want=0", d); end
    endtask

    task automatic test_div_clamp();
        logic [31:0] d;
        logic [31:0] v;
        v = $urandom_range(0, 3);
        bus_access(A_DIV, v, 1'b1, d);
        bus_access(A_DIV, 0, 1'b0, d);
        vectors++;
        if (d !== 32'd4) begin miscompares++; $display("FAIL div_clamp wrote=%0d got=%0d want=4", v, d); end
        v = $urandom_range(5, 60000);
        bus_access(A_DIV, v, 1'b1, d);
        bus_access(A_DIV, 0, 1'b0, d);
        vectors++;
        if (d !== v) begin miscompares++; $display("FAIL div_write got=%0d want=%0d", d, v); end
    endtask

    task automatic test_rx_single();
        logic [31:0] d, exp;
        setup_uart(32'h3);
        send_frame(8'hA5, 1'b1);
        model_rx(8'hA5, 1'b1);
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL rx_status got=%h want=%h", d, exp); end
        vectors++;
        if (io_irq !== 1'b1) begin miscompares++; $display("FAIL rx_irq got=%b want=1", io_irq); end
        bus_access(A_DATA, 0, 1'b0, d);
        exp = model_pop();
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL rx_data got=%h want=%h", d, exp); end
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp || io_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_drained got=%h irq=%b want=%h irq=0", d, io_irq, exp);
        end
        bus_access(A_DATA, 0, 1'b0, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL empty_read got=%h want=0", d); end
    endtask

    task automatic test_rx_random();
        logic [31:0] d, exp;
        logic [7:0] b;
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1);
                model_rx(b, 1'b1);
            end
            bus_access(A_STATUS, 0, 1'b0, d);
            exp = model_status(1'b1);
            vectors++;
            if (d !== exp) begin miscompares++; $display("FAIL rand_status round=%0d got=%h want=%h", r, d, exp); end
            for (int k = 0; k < n; k++) begin
                bus_access(A_DATA, 0, 1'b0, d);
                exp = model_pop();
                vectors++;
                if (d !== exp) begin miscompares++; $display("FAIL rand_data round=%0d got=%h want=%h", r, d, exp); end
            end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d, exp;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1);
            model_rx(8'(k), 1'b1);
        end
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL overrun_status got=%h want=%h", d, exp); end
        for (int k = 0; k < DEPTH; k++) begin
            bus_access(A_DATA, 0, 1'b0, d);
            exp = model_pop();
            vectors++;
            if (d !== exp) begin miscompares++; $display("FAIL overrun_data idx=%0d got=%h want=%h", k, d, exp); end
        end
        bus_access(A_STATUS, 32'h4, 1'b1, d);
        m_ovr = 1'b0;
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL overrun_w1c got=%h want=%h", d, exp); end
    endtask

    task automatic test_frame_glitch();
        logic [31:0] d, exp;
        send_frame(8'($urandom), 1'b0);
        model_rx(8'h00, 1'b0);
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL frame_err_status got=%h want=%h", d, exp); end
        bus_access(A_STATUS, 32'h8, 1'b1, d);
        m_ferr = 1'b0;
        @(negedge clock);
        io_uart_rx = 1'b0;
        repeat (DIV / 4) @(negedge clock);
        io_uart_rx = 1'b1;
        repeat (12 * DIV) @(negedge clock);
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL glitch_status got=%h want=%h", d, exp); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [7:0] bytes[2];
        logic [9:0] fr;
        int c0;
        bytes[0] = 8'h3C;
        bytes[1] = 8'($urandom);
        for (int t = 0; t < 2; t++) begin
            fr = {1'b1, bytes[t], 1'b0};
            bus_access(A_DATA, {24'd0, bytes[t]}, 1'b1, d);
            c0 = cyc;
            bus_access(A_STATUS, 0, 1'b0, d);
            vectors++;
            if (d[0] !== 1'b0) begin miscompares++; $display("FAIL tx_busy byte=%h got=%b want=0", bytes[t], d[0]); end
            for (int k = 0; k < 10; k++) begin
                wait_cyc(c0 + DIV * k + DIV / 2);
                vectors++;
                if (io_uart_tx !== fr[k]) begin
                    miscompares++;
                    $display("FAIL tx_bit byte=%h bit=%0d got=%b want=%b", bytes[t], k, io_uart_tx, fr[k]);
                end
            end
            wait_cyc(c0 + 10 * DIV - 3);
            bus_access(A_STATUS, 0, 1'b0, d);
            vectors++;
            if (d[0] !== 1'b0) begin miscompares++; $display("FAIL tx_busy_end got=%b want=0", d[0]); end
            wait_cyc(c0 + 10 * DIV + 1);
            bus_access(A_STATUS, 0, 1'b0, d);
            vectors++;
            if (d[0] !== 1'b1) begin miscompares++; $display("FAIL tx_ready_return got=%b want=1", d[0]); end
        end
    endtask

    task automatic test_enable_off();
        logic [31:0] d, exp;
        send_frame(8'h11, 1'b1);
        model_rx(8'h11, 1'b1);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                logic [31:0] dd;
                repeat (3 * DIV) @(negedge clock);
                bus_access(A_CONTROL, 32'h0, 1'b1, dd);
            end
        join
        bus_access(A_DATA, 32'h00, 1'b1, d);
        repeat (DIV) @(posedge clock);
        #1;
        vectors++;
        if (io_uart_tx !== 1'b1) begin miscompares++; $display("FAIL disabled_tx got=%b want=1", io_uart_tx); end
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL disabled_status got=%h want=%h", d, exp); end
        bus_access(A_DATA, 0, 1'b0, d);
        exp = model_pop();
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL fifo_kept got=%h want=%h", d, exp); end
        bus_access(A_CONTROL, 32'h3, 1'b1, d);
    endtask

    task automatic test_loopback();
        logic [31:0] d, exp;
`ifdef UART_LOOPBACK_EN
        int c0;
        bus_access(A_CONTROL, 32'h5, 1'b1, d);
        bus_access(A_DATA, 32'h5A, 1'b1, d);
        c0 = cyc;
        model_rx(8'h5A, 1'b1);
        wait_cyc(c0 + 10 * DIV + 2);
        bus_access(A_STATUS, 0, 1'b0, d);
        exp = model_status(1'b1);
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL loopback_status got=%h want=%h", d, exp); end
        bus_access(A_DATA, 0, 1'b0, d);
        exp = model_pop();
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL loopback_data got=%h want=%h", d, exp); end
`else
        bus_access(A_CONTROL, 32'h7, 1'b1, d);
        bus_access(A_CONTROL, 0, 1'b0, d);
        exp = 32'h3;
        vectors++;
        if (d !== exp) begin miscompares++; $display("FAIL control_mask got=%h want=%h", d, exp); end
`endif
        bus_access(A_CONTROL, 32'h3, 1'b1, d);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int c0;
        bus_access(A_DATA, 32'h00, 1'b1, d);
        c0 = cyc;
        wait_cyc(c0 + 3 * DIV);
        vectors++;
        if (io_uart_tx !== 1'b0) begin miscompares++; $display("FAIL midframe_tx got=%b want=0", io_uart_tx); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (io_uart_tx !== 1'b1 || io_reg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset tx=%b ready=%b want 1 0", io_uart_tx, io_reg_ready);
        end
        do_reset();
        bus_access(A_DIV, 0, 1'b0, d);
        vectors++;
        if (d !== 32'd434) begin miscompares++; $display("FAIL post_reset_div got=%0d want=434", d); end
        bus_access(A_STATUS, 0, 1'b0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL post_reset_status got=%h want=1", d); end
    endtask

    initial begin
        reset_n      = 1'b0;
        io_reg_valid = 1'b0;
        io_reg_addr  = '0;
        io_reg_wdata = '0;
        io_reg_wen   = 1'b0;
        io_reg_ren   = 1'b0;
        io_uart_rx   = 1'b1;
        test_reset();
        test_div_clamp();
        test_rx_single();
        test_rx_random();
        test_overrun();
        test_frame_glitch();
        test_tx();
        test_enable_off();
        test_loopback();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
